// File: rtl/misr_4bit.sv
// misr_4bit: 4-bit Galois MISR (x^4+x+1, zero seed) compressing a 2-bit response word per clock
module misr_4bit (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] dataIn,
  output logic [3:0] Q
);
  always_ff @(posedge clock)
    Q <= reset ? 4'b0000 : {Q[2], Q[1], Q[0] ^ Q[3] ^ dataIn[1], Q[3] ^ dataIn[0]};
endmodule

// File: tb/tb_misr_4bit.sv
// tb_misr_4bit: table-driven and scoreboard checks of the MISR signature sequences
module tb_misr_4bit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dataIn = 2'b00;
  logic [3:0] Q;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic       rst;
    logic [1:0] d;
    logic [3:0] q;
    string      name;
  } vec_t;
  vec_t tbl[$];
  logic [3:0] sb[$];
  logic [1:0] ref_d [7] = '{2'b10, 2'b01, 2'b01, 2'b11, 2'b01, 2'b10, 2'b10};
  logic [3:0] ref_q [7] = '{4'b0010, 4'b0101, 4'b1011, 4'b0110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] auto_q [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0011};
  logic [3:0] s;

  always #5 clock = ~clock;

  misr_4bit dut (.clock(clock), .reset(reset), .dataIn(dataIn), .Q(Q));

  function automatic logic [3:0] model(input logic [3:0] st, input logic [1:0] d);
    return {st[2], st[1], st[0] ^ st[3] ^ d[1], st[3] ^ d[0]};
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] d, input logic [3:0] exp, input string name);
    @(negedge clock);
    reset = r;
    dataIn = d;
    sb.push_back(exp);
    @(posedge clock);
    #1;
    check(name, Q, sb.pop_front());
  endtask

  initial begin
    tbl.push_back('{1'b1, 2'bxx, 4'b0000, "reset_x"});
    tbl.push_back('{1'b1, 2'bxx, 4'b0000, "reset_hold1"});
    tbl.push_back('{1'b1, 2'b11, 4'b0000, "reset_hold2"});
    for (int i = 0; i < 7; i++)
      tbl.push_back('{1'b0, ref_d[i], ref_q[i], $sformatf("ref%0d", i)});
    tbl.push_back('{1'b0, 2'b10, 4'b1100, "ref_extra"});
    foreach (tbl[i]) step(tbl[i].rst, tbl[i].d, tbl[i].q, tbl[i].name);

    step(1'b1, 2'b00, 4'b0000, "auto_reset");
    step(1'b0, 2'b01, 4'b0001, "auto_seed");
    s = 4'b0001;
    for (int i = 1; i <= 15; i++) begin
      s = model(s, 2'b00);
      step(1'b0, 2'b00, s, $sformatf("auto%0d", i));
      if (i <= 4) check($sformatf("auto_const%0d", i), Q, auto_q[i-1]);
      if (i < 15) begin
        checks++;
        if (Q === 4'b0001) begin
          errors++;
          $display("FAIL auto_early_repeat%0d: got %b required not 0001", i, Q);
        end
      end
    end
    check("auto_period", Q, 4'b0001);

    step(1'b1, 2'b00, 4'b0000, "zero_reset");
    for (int i = 0; i < 20; i++) step(1'b0, 2'b00, 4'b0000, $sformatf("zero%0d", i));

    step(1'b1, 2'b00, 4'b0000, "mid_reset0");
    for (int i = 0; i < 4; i++) step(1'b0, ref_d[i], ref_q[i], $sformatf("mid_pre%0d", i));
    reset = 1'b1;
    #2;
    check("reset_between_edges", Q, 4'b0110);
    reset = 1'b0;
    step(1'b1, 2'b11, 4'b0000, "mid_reset");
    for (int i = 0; i < 7; i++) step(1'b0, ref_d[i], ref_q[i], $sformatf("mid_replay%0d", i));

    step(1'b1, 2'b00, 4'b0000, "alias_reset");
    s = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      s = model(s, i == 3 ? 2'b10 : ref_d[i]);
      step(1'b0, i == 3 ? 2'b10 : ref_d[i], s, $sformatf("alias%0d", i));
    end
    checks++;
    if (Q === 4'b0111) begin
      errors++;
      $display("FAIL alias_differs: got %b required not 0111", Q);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
